led_sequencer: RTL and testbench
================================

LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 5000000, clock cycles per animation step (10 Hz at 50 MHz); legal range 2 or more.
REQ-002 Parameter NUM_LEDS, default 10, number of LED positions; led_number ranges 0..NUM_LEDS-1.
REQ-003 Port clk  input  1  single system clock; all state is updated on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port mode  input  2  display mode: 00 HOLD, 01 CHASE, 10 BOUNCE, 11 reserved (treated as HOLD).
REQ-006 Port hold_value  input  4  position displayed in HOLD.
REQ-007 Port pause  input  1  level; freezes animation while high.
REQ-008 Port jump_valid  input  1  request to load the position immediately.
REQ-009 Port jump_value  input  4  target position for the jump.
REQ-010 Port jump_ready  output  1  jump acceptance; a jump transfers on jump_valid&jump_ready at a rising edge.
REQ-011 Port led_number  output  4  registered position, feeds the LED one-hot decoder.
REQ-012 Port busy  output  1  high in CHASE or BOUNCE.
REQ-013 Port wrap_pulse  output  1  one-cycle pulse on a CHASE wrap or a BOUNCE end reversal.

Function
REQ-014 FSM states: HOLD, CHASE, BOUNCE, PAUSED; mode is sampled every cycle.
REQ-015 In the next cycle, mode selects HOLD/CHASE/BOUNCE; a mode change clears the prescaler and keeps led_number.
REQ-016 Prescaler: counts 0..TICK_DIV-1; tick asserted for one cycle when count==TICK_DIV-1, then count wraps to 0.
REQ-017 HOLD: led_number <= min(hold_value, NUM_LEDS-1) every cycle; the prescaler is held at 0.
REQ-018 CHASE on tick: led_number increments; NUM_LEDS-1 wraps to 0, and wrap_pulse=1 in the cycle the 0 is registered.
REQ-019 BOUNCE: a dir register (1=up) steps on tick; at NUM_LEDS-1 going up, or 0 going down, dir flips and the position steps away from the end.
REQ-020 BOUNCE reversal: wrap_pulse=1 in the cycle the end value is reached; dir is set to up on entry to BOUNCE.
REQ-021 Step latency: led_number changes on the edge following the tick cycle, exactly one update per tick.
REQ-022 jump_ready=1 only in CHASE or BOUNCE.
REQ-023 Accepted jump: led_number <= min(jump_value, NUM_LEDS-1) and the prescaler clears.
REQ-024 A jump has priority over a coincident tick; no step and no wrap_pulse occur in that cycle.
REQ-025 pause=1 while in CHASE/BOUNCE: enter PAUSED; the prescaler, led_number and dir freeze, and jump_ready=0.
REQ-026 pause=0 in PAUSED: return to the state selected by mode, resuming the prescaler from its frozen count.
REQ-027 A mode change during pause is taken on resume; pause is ignored in HOLD.
REQ-028 busy=1 in CHASE/BOUNCE and 0 in HOLD/PAUSED; wrap_pulse is never high for more than one cycle.

Reset
REQ-029 Reset asserted: state=HOLD, led_number=0, dir=up, prescaler=0, wrap_pulse=0, busy=0, jump_ready=0, regardless of the clock.
REQ-030 Reset mid-animation or mid-jump discards the pending step or jump; normal operation resumes on the first edge after deassertion.

Configuration
REQ-031 Macro LED_SEQ_PAUSE_EN defined: the pause input and PAUSED state are implemented as specified.
REQ-032 Macro LED_SEQ_PAUSE_EN undefined: the pause port remains but is ignored, and the PAUSED state is absent.

Structure
REQ-033 Shared package led_pkg holds: the mode encodings, the state enum, LED_NUM_W=4 and the NUM_LEDS default.
REQ-034 The prescaler is a separate sub-module, led_tick_gen, with ports clk, reset, clear, hold and tick.

Verification (TICK_DIV=4, NUM_LEDS=10)
REQ-035 reset pulse during CHASE at position 6 -> led_number=0, busy=0 and jump_ready=0 immediately, without waiting for a clock edge.
REQ-036 mode=01 from 0 for 40 cycles -> steps every 4 cycles; 9->0 sets wrap_pulse for exactly one cycle.
REQ-037 mode=10 from 8 -> sequence 9,8,7; wrap_pulse fires on reaching 9; after a 0 is reached, the next value is 1.
REQ-038 mode=00, hold_value=12 -> led_number=9; jump_valid=1 gives jump_ready=0 and no change.
REQ-039 CHASE with jump_valid and jump_value=3 coincident with a tick -> led_number=3, no step, and the next step comes 4 cycles later.
REQ-040 CHASE with pause held for 10 cycles -> led_number is frozen and busy=0; the first step after release equals the remaining prescaler count (macro on).
REQ-041 CHASE with pause held for 10 cycles, macro off -> stepping continues unaffected.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the LED sequencer.
// LED_SEQ_PAUSE_EN adds the PAUSED state to the state enum.
package led_pkg;

   localparam int unsigned LED_NUM_W        = 4;
   localparam int unsigned LED_NUM_LEDS_DEF = 10;

   typedef enum logic [1:0] {
      MODE_HOLD   = 2'b00,
      MODE_CHASE  = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_e;

`ifdef LED_SEQ_PAUSE_EN
   typedef enum logic [1:0] {
      ST_HOLD   = 2'd0,
      ST_CHASE  = 2'd1,
      ST_BOUNCE = 2'd2,
      ST_PAUSED = 2'd3
   } state_e;
`else
   typedef enum logic [1:0] {
      ST_HOLD   = 2'd0,
      ST_CHASE  = 2'd1,
      ST_BOUNCE = 2'd2
   } state_e;
`endif

   // Saturate a requested position to the last LED index.
   function automatic logic [LED_NUM_W-1:0] clamp_pos(input logic [LED_NUM_W-1:0] v,
                                                      input logic [LED_NUM_W-1:0] last);
      return (v > last) ? last : v;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Animation prescaler: counts 0..TICK_DIV-1 and flags the terminal count.
// clear has priority over hold; tick is suppressed while held.
module led_tick_gen #(
   parameter int unsigned TICK_DIV = 5000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic hold,
   output logic tick
);

   localparam int unsigned      CNT_W   = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (!hold) begin
         r_count <= (r_count == CNT_MAX) ? '0 : r_count + CNT_W'(1);
      end
   end

   assign tick = (r_count == CNT_MAX) && !hold;

endmodule

// File: rtl/led_sequencer.sv
// LED position sequencer with HOLD / CHASE / BOUNCE display modes and jump loads.
// Define LED_SEQ_PAUSE_EN to implement the pause input and PAUSED state.
module led_sequencer
   import led_pkg::*;
#(
   parameter int unsigned TICK_DIV = 5000000,
   parameter int unsigned NUM_LEDS = LED_NUM_LEDS_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           mode,
   input  logic [LED_NUM_W-1:0] hold_value,
   input  logic                 pause,
   input  logic                 jump_valid,
   input  logic [LED_NUM_W-1:0] jump_value,
   output logic                 jump_ready,
   output logic [LED_NUM_W-1:0] led_number,
   output logic                 busy,
   output logic                 wrap_pulse
);

   localparam logic [LED_NUM_W-1:0] LAST = LED_NUM_W'(NUM_LEDS - 1);
   localparam logic [LED_NUM_W-1:0] ONE  = LED_NUM_W'(1);

   state_e               r_state;
   state_e               w_state_nxt;
   state_e               w_mode_state;
   logic [LED_NUM_W-1:0] r_led;
   logic [LED_NUM_W-1:0] w_led_nxt;
   logic                 r_dir;
   logic                 w_dir_nxt;
   logic                 r_wrap;
   logic                 w_wrap_nxt;
   logic                 r_busy;
   logic                 r_jump_ready;
   logic                 w_run_nxt;
   logic                 w_clear;
   logic                 w_hold;
   logic                 w_tick;

`ifdef LED_SEQ_PAUSE_EN
   logic w_pause;
   assign w_pause = pause;
`else
   logic w_unused_pause;
   assign w_unused_pause = pause;
`endif

   led_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .clear (w_clear),
      .hold  (w_hold),
      .tick  (w_tick)
   );

   // Run state requested by the mode input; the reserved code behaves as HOLD.
   always_comb begin
      w_mode_state = ST_HOLD;
      case (mode)
         MODE_CHASE:  w_mode_state = ST_CHASE;
         MODE_BOUNCE: w_mode_state = ST_BOUNCE;
         default:     w_mode_state = ST_HOLD;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_led_nxt   = r_led;
      w_dir_nxt   = r_dir;
      w_wrap_nxt  = 1'b0;
      w_clear     = 1'b0;
      w_hold      = 1'b0;

      case (r_state)
         ST_HOLD: begin
            w_state_nxt = w_mode_state;
            w_clear     = 1'b1;
            w_dir_nxt   = 1'b1;
            if (w_mode_state == ST_HOLD) begin
               w_led_nxt = clamp_pos(hold_value, LAST);
            end
         end

         ST_CHASE, ST_BOUNCE: begin
`ifdef LED_SEQ_PAUSE_EN
            w_state_nxt = w_pause ? ST_PAUSED : w_mode_state;
`else
            w_state_nxt = w_mode_state;
`endif
            if (r_state == ST_CHASE) begin
               w_dir_nxt = 1'b1;
            end
            // Jump beats a coincident tick; a mode change restarts the prescaler without stepping.
            if (jump_valid && r_jump_ready) begin
               w_led_nxt = clamp_pos(jump_value, LAST);
               w_clear   = 1'b1;
            end else if (w_mode_state != r_state) begin
               w_clear = 1'b1;
            end else if (w_tick) begin
               if (r_state == ST_CHASE) begin
                  if (r_led == LAST) begin
                     w_led_nxt  = '0;
                     w_wrap_nxt = 1'b1;
                  end else begin
                     w_led_nxt = r_led + ONE;
                  end
               end else if (r_dir) begin
                  if (r_led == LAST) begin
                     w_dir_nxt = 1'b0;
                     w_led_nxt = r_led - ONE;
                  end else begin
                     w_led_nxt  = r_led + ONE;
                     w_wrap_nxt = (r_led == LAST - ONE);
                  end
               end else begin
                  if (r_led == '0) begin
                     w_dir_nxt = 1'b1;
                     w_led_nxt = ONE;
                  end else begin
                     w_led_nxt  = r_led - ONE;
                     w_wrap_nxt = (r_led == ONE);
                  end
               end
            end
         end

`ifdef LED_SEQ_PAUSE_EN
         ST_PAUSED: begin
            w_hold = 1'b1;
            if (!w_pause) begin
               w_state_nxt = w_mode_state;
            end
         end
`endif

         default: begin
            w_state_nxt = ST_HOLD;
         end
      endcase

      w_run_nxt = (w_state_nxt == ST_CHASE) || (w_state_nxt == ST_BOUNCE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_HOLD;
         r_led        <= '0;
         r_dir        <= 1'b1;
         r_wrap       <= 1'b0;
         r_busy       <= 1'b0;
         r_jump_ready <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_led        <= w_led_nxt;
         r_dir        <= w_dir_nxt;
         r_wrap       <= w_wrap_nxt;
         r_busy       <= w_run_nxt;
         r_jump_ready <= w_run_nxt;
      end
   end

   assign led_number = r_led;
   assign busy       = r_busy;
   assign jump_ready = r_jump_ready;
   assign wrap_pulse = r_wrap;

endmodule

// File: tb/tb_led_sequencer.sv
// Randomized self-checking bench for led_sequencer against a behavioural model.
// Honours LED_SEQ_PAUSE_EN to select the expected pause behaviour.
module tb_led_sequencer;

   localparam int TD = 4;
   localparam int N  = 10;
`ifdef LED_SEQ_PAUSE_EN
   localparam bit PAUSE_EN = 1'b1;
`else
   localparam bit PAUSE_EN = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic [1:0] mode;
   logic [3:0] hold_value;
   logic       pause;
   logic       jump_valid;
   logic [3:0] jump_value;
   logic       jump_ready;
   logic [3:0] led_number;
   logic       busy;
   logic       wrap_pulse;
   logic [6:0] obs;

   int vectors;
   int miscompares;

   // Model: m_st 0=hold 1=chase 2=bounce 3=paused; m_cnt is the prescaler count this cycle.
   int m_st, m_pos, m_up, m_cnt, m_wrap;

   led_sequencer #(.TICK_DIV(TD), .NUM_LEDS(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .mode       (mode),
      .hold_value (hold_value),
      .pause      (pause),
      .jump_valid (jump_valid),
      .jump_value (jump_value),
      .jump_ready (jump_ready),
      .led_number (led_number),
      .busy       (busy),
      .wrap_pulse (wrap_pulse)
   );

   assign obs = {led_number, busy, jump_ready, wrap_pulse};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int clampf(input int v);
      return (v > N - 1) ? N - 1 : v;
   endfunction

   function automatic logic [6:0] model_vec();
      logic run;
      run = (m_st == 1) || (m_st == 2);
      return {4'(m_pos), run, run, 1'(m_wrap)};
   endfunction

   task automatic model_reset();
      m_st = 0; m_pos = 0; m_up = 1; m_cnt = 0; m_wrap = 0;
   endtask

   // Advance one clock: model consumes the inputs present at the edge, then settle.
   task automatic cycle();
      int sel;
      @(posedge clk);
      if (reset) begin
         model_reset();
      end else begin
         sel    = (mode == 2'd1) ? 1 : (mode == 2'd2) ? 2 : 0;
         m_wrap = 0;
         if (m_st == 0) begin
            if (sel == 0) m_pos = clampf(int'(hold_value));
            m_cnt = 0;
            m_up  = 1;
            m_st  = sel;
         end else if (m_st == 1 || m_st == 2) begin
            if (m_st == 1) m_up = 1;
            if (jump_valid) begin
               m_pos = clampf(int'(jump_value));
               m_cnt = 0;
            end else if (sel != m_st) begin
               m_cnt = 0;
            end else if (m_cnt == TD - 1) begin
               m_cnt = 0;
               if (m_st == 1) begin
                  m_pos  = (m_pos + 1) % N;
                  m_wrap = (m_pos == 0);
               end else begin
                  if (m_up == 1 && m_pos == N - 1) m_up = 0;
                  else if (m_up == 0 && m_pos == 0) m_up = 1;
                  else m_wrap = (m_up == 1) ? (m_pos + 1 == N - 1) : (m_pos - 1 == 0);
                  m_pos = (m_up == 1) ? m_pos + 1 : m_pos - 1;
               end
            end else begin
               m_cnt = m_cnt + 1;
            end
            m_st = (PAUSE_EN && pause) ? 3 : sel;
         end else begin
            if (!pause) m_st = sel;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; mode = 2'd0; hold_value = 4'd0; pause = 1'b0;
      jump_valid = 1'b0; jump_value = 4'd0;
      model_reset();
      #12;
      vectors++;
      if (obs !== 7'h00) begin
         miscompares++;
         $display("FAIL reset_state: got %h expected %h", obs, 7'h00);
      end
      cycle();
      reset = 1'b0;
      cycle();
      vectors++;
      if (obs !== model_vec()) begin
         miscompares++;
         $display("FAIL reset_release: got %h expected %h", obs, model_vec());
      end
   endtask

   task automatic test_hold();
      mode = 2'd0; hold_value = 4'd12;
      cycle(); cycle();
      vectors++;
      if (led_number !== 4'd9 || jump_ready !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_clamp: got led=%0d rdy=%b busy=%b expected led=9 rdy=0 busy=0",
                  led_number, jump_ready, busy);
      end
      jump_valid = 1'b1; jump_value = 4'd2;
      for (int i = 0; i < 3; i++) begin
         cycle();
         vectors++;
         if (obs !== model_vec() || led_number !== 4'd9) begin
            miscompares++;
            $display("FAIL hold_jump_ignored: got %h expected %h", obs, model_vec());
         end
      end
      jump_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         hold_value = 4'($urandom_range(0, 15));
         if (i == 7) mode = 2'd3;
         cycle();
         vectors++;
         if (obs !== model_vec()) begin
            miscompares++;
            $display("FAIL hold_random: hv=%0d got %h expected %h", hold_value, obs, model_vec());
         end
      end
   endtask

   task automatic test_chase();
      int wraps;
      wraps = 0;
      mode = 2'd0; hold_value = 4'd0;
      cycle(); cycle();
      mode = 2'd1;
      for (int i = 0; i < 44; i++) begin
         cycle();
         if (wrap_pulse === 1'b1) wraps++;
         vectors++;
         if (obs !== model_vec()) begin
            miscompares++;
            $display("FAIL chase cyc %0d: got %h expected %h", i, obs, model_vec());
         end
      end
      vectors++;
      if (wraps != 1) begin
         miscompares++;
         $display("FAIL chase_wrap_count: got %0d expected 1", wraps);
      end
   endtask

   task automatic test_bounce();
      int seq[$];
      int zi;
      logic [3:0] prev;
      mode = 2'd0; hold_value = 4'd8;
      cycle(); cycle();
      prev = led_number;
      mode = 2'd2;
      for (int i = 0; i < 60; i++) begin
         cycle();
         if (led_number !== prev) seq.push_back(int'(led_number));
         prev = led_number;
         vectors++;
         if (obs !== model_vec()) begin
            miscompares++;
            $display("FAIL bounce cyc %0d: got %h expected %h", i, obs, model_vec());
         end
      end
      zi = -1;
      for (int i = 0; i < seq.size() - 1; i++) if (zi < 0 && seq[i] == 0) zi = i;
      vectors++;
      if (seq.size() < 12 || seq[0] != 9 || seq[1] != 8 || seq[2] != 7 || zi < 0 || seq[zi+1] != 1) begin
         miscompares++;
         $display("FAIL bounce_sequence: got %p expected 9,8,7,...,0,1", seq);
      end
   endtask

   task automatic test_jump_tick();
      bit found;
      int n;
      found = 1'b0;
      mode = 2'd1;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         vectors++;
         if (obs !== model_vec()) begin
            miscompares++;
            $display("FAIL jump_setup: got %h expected %h", obs, model_vec());
         end
         if (m_st == 1 && m_cnt == TD - 1) found = 1'b1;
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL jump_tick_search: got no tick cycle expected one within 20 cycles");
      end
      jump_valid = 1'b1; jump_value = 4'd3;
      cycle();
      jump_valid = 1'b0;
      vectors++;
      if (led_number !== 4'd3 || wrap_pulse !== 1'b0 || obs !== model_vec()) begin
         miscompares++;
         $display("FAIL jump_over_tick: got %h expected led=3 (%h)", obs, model_vec());
      end
      n = 0;
      while (led_number === 4'd3 && n < 10) begin
         cycle();
         n++;
      end
      vectors++;
      if (n != TD || led_number !== 4'd4) begin
         miscompares++;
         $display("FAIL jump_next_step: got %0d cycles led=%0d expected %0d cycles led=4",
                  n, led_number, TD);
      end
   endtask

   task automatic test_pause();
      logic exp_busy;
      mode = 2'd1;
      for (int i = 0; i < 6; i++) cycle();
      pause = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         vectors++;
         if (obs !== model_vec()) begin
            miscompares++;
            $display("FAIL pause_hold cyc %0d: got %h expected %h", i, obs, model_vec());
         end
      end
      exp_busy = PAUSE_EN ? 1'b0 : 1'b1;
      vectors++;
      if (busy !== exp_busy) begin
         miscompares++;
         $display("FAIL pause_busy: got %b expected %b", busy, exp_busy);
      end
      pause = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         vectors++;
         if (obs !== model_vec()) begin
            miscompares++;
            $display("FAIL pause_resume cyc %0d: got %h expected %h", i, obs, model_vec());
         end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      mode = 2'd1;
      n = 0;
      while (m_pos != 6 && n < 100) begin
         cycle();
         n++;
      end
      vectors++;
      if (led_number !== 4'd6 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid_setup: got led=%0d busy=%b expected led=6 busy=1", led_number, busy);
      end
      #2 reset = 1'b1;
      #1;
      model_reset();
      vectors++;
      if (obs !== 7'h00) begin
         miscompares++;
         $display("FAIL reset_async: got %h expected %h", obs, 7'h00);
      end
      cycle();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         vectors++;
         if (obs !== model_vec()) begin
            miscompares++;
            $display("FAIL reset_recover cyc %0d: got %h expected %h", i, obs, model_vec());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) pause = ~pause;
         hold_value = 4'($urandom_range(0, 15));
         jump_valid = ($urandom_range(0, 9) == 0);
         jump_value = 4'($urandom_range(0, 15));
         cycle();
         vectors++;
         if (obs !== model_vec()) begin
            miscompares++;
            $display("FAIL random cyc %0d: got %h expected %h", i, obs, model_vec());
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_hold();
      test_chase();
      test_bounce();
      test_jump_tick();
      test_pause();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
